hs_ram_arbiter: RTL and testbench

Arbitrates the game core's work-RAM port between the Z80 CPU path and the hiscore save/restore engine. A hiscore transaction pauses the CPU through the pause path and waits for the pause acknowledge. It then switches RAM ownership, performs a single read or write, and returns ownership to the CPU. A hold mode keeps the CPU paused across back-to-back hiscore transactions, so a full table dump or restore pauses the CPU only once.

---
 rtl/hs_ram_arbiter_if.sv | 26 ++
 rtl/hs_ram_arbiter.sv | 174 +++++++++++++++++
 tb/tb_hs_ram_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hs_ram_arbiter_if.sv
// Hiscore engine <-> RAM arbiter request/response bundle.
interface hs_ram_arbiter_if #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 8
) ();
    logic          hs_req;
    logic          hs_we;
    logic          hs_hold;
    logic [AW-1:0] hs_addr;
    logic [DW-1:0] hs_wdata;
    logic [DW-1:0] hs_rdata;
    logic          hs_ack;
    logic          hs_busy;

    // Hiscore engine side: issues requests, receives completion.
    modport master (
        output hs_req, hs_we, hs_hold, hs_addr, hs_wdata,
        input  hs_rdata, hs_ack, hs_busy
    );

    // Arbiter side.
    modport slave (
        input  hs_req, hs_we, hs_hold, hs_addr, hs_wdata,
        output hs_rdata, hs_ack, hs_busy
    );
endinterface

// File: rtl/hs_ram_arbiter.sv
// Work-RAM arbiter: pauses the CPU, lends the RAM port to the hiscore
// engine for one access, then hands it back (or keeps it in hold mode).
module hs_ram_arbiter #(
    parameter int unsigned AW     = 16,
    parameter int unsigned DW     = 8,
    parameter int unsigned SETTLE = 2,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    hs_ram_arbiter_if.slave hs,
    output logic          pause_req,
    input  logic          cpu_paused,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          cpu_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    input  logic [DW-1:0] ram_rdata
);

    localparam int unsigned SCW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam int unsigned RCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [SCW-1:0] SETTLE_LOAD = SCW'((SETTLE == 0) ? 0 : SETTLE - 1);
    localparam logic [RCW-1:0] RD_LOAD     = RCW'((RD_LAT == 0) ? 0 : RD_LAT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PAUSING,
        ST_SETTLE,
        ST_ACCESS,
        ST_WAIT_RD,
        ST_DONE,
        ST_HOLD
    } state_t;

    state_t        state, state_d;
    logic [SCW-1:0] settle_cnt, settle_cnt_d;
    logic [RCW-1:0] rd_cnt, rd_cnt_d;
    logic          accept;
    logic          armed;
    logic          owner_hs;
    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;

    // Next-state logic, settle/read-latency countdowns and request accept.
    always_comb begin
        state_d      = state;
        settle_cnt_d = settle_cnt;
        rd_cnt_d     = rd_cnt;
        accept       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (hs.hs_req && armed) begin
                    accept  = 1'b1;
                    state_d = ST_PAUSING;
                end
            end
            ST_PAUSING: begin
                if (!hs.hs_req) begin
                    state_d = ST_IDLE;
                end else if (cpu_paused) begin
                    if (SETTLE == 0) begin
                        state_d = ST_ACCESS;
                    end else begin
                        state_d      = ST_SETTLE;
                        settle_cnt_d = SETTLE_LOAD;
                    end
                end
            end
            ST_SETTLE: begin
                if (!hs.hs_req) begin
                    state_d = ST_IDLE;
                end else if (!cpu_paused) begin
                    state_d = ST_PAUSING;
                end else if (settle_cnt == '0) begin
                    state_d = ST_ACCESS;
                end else begin
                    settle_cnt_d = settle_cnt - SCW'(1);
                end
            end
            ST_ACCESS: begin
                if (lat_we) begin
                    state_d = ST_DONE;
                end else begin
                    state_d  = ST_WAIT_RD;
                    rd_cnt_d = RD_LOAD;
                end
            end
            ST_WAIT_RD: begin
                if (rd_cnt == '0) begin
                    state_d = ST_DONE;
                end else begin
                    rd_cnt_d = rd_cnt - RCW'(1);
                end
            end
            ST_DONE: begin
                state_d = hs.hs_hold ? ST_HOLD : ST_IDLE;
            end
            ST_HOLD: begin
                if (hs.hs_req && armed) begin
                    accept  = 1'b1;
                    state_d = ST_ACCESS;
                end else if (!hs.hs_hold) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counters and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            rd_cnt     <= '0;
            pause_req  <= 1'b0;
            owner_hs   <= 1'b0;
            hs.hs_ack  <= 1'b0;
        end else begin
            state      <= state_d;
            settle_cnt <= settle_cnt_d;
            rd_cnt     <= rd_cnt_d;
            pause_req  <= (state_d != ST_IDLE);
            owner_hs   <= (state_d != ST_IDLE) && (state_d != ST_PAUSING);
            hs.hs_ack  <= (state_d == ST_DONE);
        end
    end

    // Request latch, re-arm tracking and read-data capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            armed       <= 1'b1;
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            hs.hs_rdata <= '0;
        end else begin
            // A low request re-arms; completing a transaction disarms so a
            // request left high after ack cannot start a second access.
            if (!hs.hs_req) begin
                armed <= 1'b1;
            end else if (state == ST_DONE) begin
                armed <= 1'b0;
            end
            if (accept) begin
                lat_we    <= hs.hs_we;
                lat_addr  <= hs.hs_addr;
                lat_wdata <= hs.hs_wdata;
            end
            if ((state == ST_WAIT_RD) && (rd_cnt == '0)) begin
                hs.hs_rdata <= ram_rdata;
            end
        end
    end

    assign hs.hs_busy = owner_hs;

    // RAM port mux, zero-latency pass-through while the CPU owns it.
    always_comb begin
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        ram_we    = cpu_we;
        if (owner_hs) begin
            ram_addr  = lat_addr;
            ram_wdata = lat_wdata;
            ram_we    = (state == ST_ACCESS) && lat_we;
        end
    end

endmodule

// File: tb/tb_hs_ram_arbiter.sv
// Scoreboard bench for hs_ram_arbiter: stimulus queues expected RAM writes
// and acks (with their cycle numbers); a negedge monitor pops and compares.
module tb_hs_ram_arbiter;

    localparam int unsigned AW     = 16;
    localparam int unsigned DW     = 8;
    localparam int unsigned SETTLE = 2;
    localparam int unsigned RD_LAT = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          pause_req;
    logic          cpu_paused;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_we;
    logic [DW-1:0] ram_rdata;

    always #5 clk = ~clk;

    hs_ram_arbiter_if #(.AW(AW), .DW(DW)) hs ();

    hs_ram_arbiter #(
        .AW(AW), .DW(DW), .SETTLE(SETTLE), .RD_LAT(RD_LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .hs        (hs),
        .pause_req (pause_req),
        .cpu_paused(cpu_paused),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata)
    );

    typedef struct { int cyc; logic rd; logic [7:0] data; } ack_exp_t;
    typedef struct { int cyc; logic [15:0] addr; logic [7:0] data; } wr_exp_t;

    ack_exp_t ack_q[$];
    wr_exp_t  wr_q[$];

    int n_tests  = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;
    bit chk_hold = 1'b0;

    logic [7:0] mem [0:65535];

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM, one cycle read latency.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_evt(input string name, input string what);
        n_tests++;
        n_fail++;
        $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a request and queue its expected write/ack; caller is one cycle
    // before the accept edge with cpu_paused already high.
    task automatic issue(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                         input logic hold, input logic in_hold, input logic [7:0] exp_rd);
        int base;
        int wcyc;
        int acyc;
        hs.hs_we    = we;
        hs.hs_addr  = addr;
        hs.hs_wdata = wd;
        hs.hs_hold  = hold;
        hs.hs_req   = 1'b1;
        base = cyc;
        wcyc = in_hold ? base + 1 : base + 2 + int'(SETTLE);
        acyc = wcyc + 1 + (we ? 0 : int'(RD_LAT));
        if (we) wr_q.push_back('{wcyc, addr, wd});
        ack_q.push_back('{acyc, !we, exp_rd});
    endtask

    task automatic wait_ack(input string name);
        int i;
        i = 0;
        do begin
            tick();
            i++;
        end while (!hs.hs_ack && i < 60);
        if (!hs.hs_ack) fail_evt(name, "no hs_ack within 60 cycles, required one");
    endtask

    // CPU side keeps changing so the pass-through mux is exercised.
    initial begin
        cpu_addr  = 16'hA000;
        cpu_wdata = 8'h00;
        cpu_we    = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cpu_addr  = 16'hA000 | 16'($urandom_range(0, 255));
            cpu_wdata = 8'($urandom);
            cpu_we    = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: RAM mux, hiscore writes, acks and hold-mode invariants.
    always @(negedge clk) begin
        wr_exp_t  w;
        ack_exp_t a;
        if (mon_en) begin
            if (!hs.hs_busy)
                check("cpu_mux", 32'({ram_we, ram_addr, ram_wdata}), 32'({cpu_we, cpu_addr, cpu_wdata}));
            if (hs.hs_busy && ram_we) begin
                if (wr_q.size() == 0) begin
                    fail_evt("unexpected_write", $sformatf("ram_we at addr 0x%0h, required none", ram_addr));
                end else begin
                    w = wr_q.pop_front();
                    check("wr_cycle", 32'(cyc), 32'(w.cyc));
                    check("wr_addr", 32'(ram_addr), 32'(w.addr));
                    check("wr_data", 32'(ram_wdata), 32'(w.data));
                end
            end
            if (hs.hs_ack) begin
                if (ack_q.size() == 0) begin
                    fail_evt("unexpected_ack", "hs_ack pulse, required none");
                end else begin
                    a = ack_q.pop_front();
                    check("ack_cycle", 32'(cyc), 32'(a.cyc));
                    if (a.rd) check("ack_rdata", 32'(hs.hs_rdata), 32'(a.data));
                end
            end
            if (chk_hold)
                check("hold_pause_busy", 32'({pause_req, hs.hs_busy}), 32'(2'b11));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0040] = 8'hC3;
        mem[16'h0041] = 8'h3C;

        reset       = 1'b1;
        cpu_paused  = 1'b1;
        hs.hs_req   = 1'b0;
        hs.hs_we    = 1'b0;
        hs.hs_hold  = 1'b0;
        hs.hs_addr  = '0;
        hs.hs_wdata = '0;

        // Reset values
        tick();
        mon_en = 1'b1;
        tick();
        check("rst_pause_req", 32'(pause_req), 32'(0));
        check("rst_hs_ack", 32'(hs.hs_ack), 32'(0));
        check("rst_hs_busy", 32'(hs.hs_busy), 32'(0));
        check("rst_hs_rdata", 32'(hs.hs_rdata), 32'(0));
        reset = 1'b0;
        tick();

        // Write 0x5A to 0x1234
        issue(1'b1, 16'h1234, 8'h5A, 1'b0, 1'b0, 8'h00);
        tick();
        check("t1_pause_c1", 32'(pause_req), 32'(1));
        check("t1_busy_c1", 32'(hs.hs_busy), 32'(0));
        wait_ack("t1_ack");
        hs.hs_req = 1'b0;
        tick();
        check("t1_pause_c6", 32'(pause_req), 32'(0));
        check("t1_busy_c6", 32'(hs.hs_busy), 32'(0));

        // Reads: preloaded 0xC3, then the value just written
        tick();
        issue(1'b0, 16'h0040, 8'h00, 1'b0, 1'b0, 8'hC3);
        wait_ack("t2_ack");
        hs.hs_req = 1'b0;
        tick();
        tick();
        check("t2_rdata_held", 32'(hs.hs_rdata), 32'(8'hC3));
        issue(1'b0, 16'h1234, 8'h00, 1'b0, 1'b0, 8'h5A);
        wait_ack("t2b_ack");
        hs.hs_req = 1'b0;
        tick();

        // Late pause acknowledge, dropped for one cycle during SETTLE
        cpu_paused = 1'b0;
        tick();
        hs.hs_we    = 1'b1;
        hs.hs_addr  = 16'h2222;
        hs.hs_wdata = 8'h77;
        hs.hs_hold  = 1'b0;
        hs.hs_req   = 1'b1;
        repeat (10) tick();
        cpu_paused = 1'b1;
        tick();
        check("t3_busy_settle", 32'(hs.hs_busy), 32'(1));
        cpu_paused = 1'b0;
        tick();
        cpu_paused = 1'b1;
        base = cyc;
        wr_q.push_back('{base + 1 + int'(SETTLE), 16'h2222, 8'h77});
        ack_q.push_back('{base + 2 + int'(SETTLE), 1'b0, 8'h00});
        wait_ack("t3_ack");
        hs.hs_req = 1'b0;
        tick();

        // Hold mode across three writes
        tick();
        issue(1'b1, 16'h3000, 8'h11, 1'b1, 1'b0, 8'h00);
        wait_ack("t4_ack0");
        chk_hold  = 1'b1;
        hs.hs_req = 1'b0;
        tick();
        issue(1'b1, 16'h3001, 8'h22, 1'b1, 1'b1, 8'h00);
        wait_ack("t4_ack1");
        hs.hs_req = 1'b0;
        tick();
        issue(1'b1, 16'h3002, 8'h33, 1'b1, 1'b1, 8'h00);
        wait_ack("t4_ack2");
        hs.hs_req = 1'b0;
        repeat (3) tick();
        chk_hold   = 1'b0;
        check("t4_busy_before_drop", 32'(hs.hs_busy), 32'(1));
        hs.hs_hold = 1'b0;
        tick();
        check("t4_pause_after_drop", 32'(pause_req), 32'(0));
        check("t4_busy_after_drop", 32'(hs.hs_busy), 32'(0));

        // Request held high after ack must not start a second transaction
        tick();
        issue(1'b1, 16'h4000, 8'h99, 1'b0, 1'b0, 8'h00);
        wait_ack("t5_ack");
        repeat (5) begin
            tick();
            check("t5_no_restart", 32'(pause_req), 32'(0));
        end
        hs.hs_req = 1'b0;
        tick();
        issue(1'b1, 16'h4001, 8'hAA, 1'b0, 1'b0, 8'h00);
        wait_ack("t5b_ack");
        hs.hs_req = 1'b0;
        tick();

        // Reset during WAIT_RD
        tick();
        hs.hs_we   = 1'b0;
        hs.hs_addr = 16'h0041;
        hs.hs_req  = 1'b1;
        repeat (5) tick();
        check("t6_busy_wait_rd", 32'(hs.hs_busy), 32'(1));
        reset     = 1'b1;
        hs.hs_req = 1'b0;
        tick();
        check("t6_rst_pause", 32'(pause_req), 32'(0));
        check("t6_rst_busy", 32'(hs.hs_busy), 32'(0));
        check("t6_rst_ack", 32'(hs.hs_ack), 32'(0));
        check("t6_rst_rdata", 32'(hs.hs_rdata), 32'(0));
        reset = 1'b0;
        repeat (3) tick();

        // hs_req dropped in PAUSING
        cpu_paused = 1'b0;
        tick();
        hs.hs_we    = 1'b1;
        hs.hs_addr  = 16'h5000;
        hs.hs_wdata = 8'hEE;
        hs.hs_req   = 1'b1;
        tick();
        check("t7_pausing", 32'(pause_req), 32'(1));
        hs.hs_req = 1'b0;
        tick();
        check("t7_abort_pause", 32'(pause_req), 32'(0));
        check("t7_abort_busy", 32'(hs.hs_busy), 32'(0));
        cpu_paused = 1'b1;
        repeat (6) tick();

        check("end_ack_q_empty", 32'(ack_q.size()), 32'(0));
        check("end_wr_q_empty", 32'(wr_q.size()), 32'(0));
        check("end_mem_2222", 32'(mem[16'h2222]), 32'(8'h77));
        check("end_mem_5000", 32'(mem[16'h5000]), 32'(8'h00));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
